// File: rtl/spike_event_fifo_pkg.sv
// Shared event format for the spike router -> event FIFO -> SPU path.
// Holds weight/tag widths, the fixed-point layout and the packed event type.
package spike_event_fifo_pkg;

    localparam int WEIGHT_W = 17;
    localparam int TAG_W    = 1;
    localparam int SIGN_BIT = 16;
    localparam int FRAC_W   = 16;
    localparam int EVENT_W  = WEIGHT_W + TAG_W;

    typedef struct packed {
        logic [WEIGHT_W-1:0] weight;
        logic [TAG_W-1:0]    src_tag;
    } spike_event_t;

    function automatic spike_event_t make_event(input logic [WEIGHT_W-1:0] weight,
                                                input logic [TAG_W-1:0]    src_tag);
        spike_event_t ev;
        ev.weight  = weight;
        ev.src_tag = src_tag;
        return ev;
    endfunction

    function automatic logic weight_is_negative(input logic [WEIGHT_W-1:0] weight);
        return weight[SIGN_BIT];
    endfunction

endpackage

// File: rtl/spike_event_fifo_mem.sv
// Event storage for spike_event_fifo: DEPTH x DATA_W register array,
// one synchronous write port and one asynchronous read port (show-ahead head).
module spike_event_mem
    import spike_event_fifo_pkg::*;
#(
    parameter int DEPTH  = 8,
    parameter int ADDR_W = 3,
    parameter int DATA_W = EVENT_W
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    // Contents are never reset: the top masks the head while empty.
    logic [DATA_W-1:0] entry_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            entry_q[waddr] <= wdata;
        end
    end

    assign rdata = entry_q[raddr];

endmodule

// File: rtl/spike_event_fifo.sv
// Show-ahead synaptic event queue feeding synaptic_processing_unit2.
// Optional almost_full output is enabled by defining ALMOST_FULL_EN.
module spike_event_fifo #(
    parameter int DEPTH    = 8,
    parameter int ADDR_W   = 3,
    parameter int WEIGHT_W = spike_event_fifo_pkg::WEIGHT_W,
    parameter int TAG_W    = spike_event_fifo_pkg::TAG_W,
    parameter int AF_LEVEL = 6
) (
    input  logic                clk,
    input  logic                asyn_reset,
    input  logic                enq,
    input  logic [WEIGHT_W-1:0] weight_in,
    input  logic [TAG_W-1:0]    src_tag_in,
    input  logic                flush,
    input  logic                req_deq,
    output logic                fifo_empty,
    output logic [WEIGHT_W-1:0] weight_out,
    output logic [TAG_W-1:0]    src_tag_out,
    output logic                full,
`ifdef ALMOST_FULL_EN
    output logic                almost_full,
`endif
    output logic [ADDR_W:0]     count,
    output logic                overflow,
    output logic                underflow
);

    localparam int DATA_W = WEIGHT_W + TAG_W;
    localparam logic [ADDR_W:0] DEPTH_CNT = (ADDR_W + 1)'(DEPTH);

    generate
        if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || (1 << ADDR_W) != DEPTH) begin : g_bad_depth
            $error("spike_event_fifo: DEPTH must be a power of two >= 2 and equal 2**ADDR_W");
        end
        if (AF_LEVEL < 1 || AF_LEVEL > DEPTH) begin : g_bad_af_level
            $error("spike_event_fifo: AF_LEVEL must lie in 1..DEPTH");
        end
    endgenerate

    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic              overflow_q, overflow_d;
    logic              underflow_q, underflow_d;

    logic              pop_ok;
    logic              push_ok;
    logic              wr_en;
    logic [DATA_W-1:0] wr_data;
    logic [DATA_W-1:0] rd_data;

    always_comb begin
        rd_ptr_d    = rd_ptr_q;
        wr_ptr_d    = wr_ptr_q;
        count_d     = count_q;
        overflow_d  = overflow_q;
        underflow_d = underflow_q;
        wr_en       = 1'b0;

        pop_ok  = req_deq && (count_q != '0);
        // A pop in the same edge frees the slot, so a full queue still accepts.
        push_ok = enq && ((count_q != DEPTH_CNT) || pop_ok);

        if (flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (pop_ok) begin
                rd_ptr_d = rd_ptr_q + ADDR_W'(1);
            end
            if (push_ok) begin
                wr_en    = 1'b1;
                wr_ptr_d = wr_ptr_q + ADDR_W'(1);
            end
            if (enq && !push_ok) begin
                overflow_d = 1'b1;
            end
            if (req_deq && !pop_ok) begin
                underflow_d = 1'b1;
            end
            case ({push_ok, pop_ok})
                2'b10:   count_d = count_q + (ADDR_W + 1)'(1);
                2'b01:   count_d = count_q - (ADDR_W + 1)'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or posedge asyn_reset) begin
        if (asyn_reset) begin
            rd_ptr_q    <= '0;
            wr_ptr_q    <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    assign wr_data = {weight_in, src_tag_in};

    spike_event_mem #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_mem (
        .clk   (clk),
        .we    (wr_en),
        .waddr (wr_ptr_q),
        .wdata (wr_data),
        .raddr (rd_ptr_q),
        .rdata (rd_data)
    );

    assign fifo_empty  = (count_q == '0);
    assign full        = (count_q == DEPTH_CNT);
    assign count       = count_q;
    assign overflow    = overflow_q;
    assign underflow   = underflow_q;
    // Stale storage must never leak onto the SPU inputs.
    assign weight_out  = fifo_empty ? '0 : rd_data[DATA_W-1:TAG_W];
    assign src_tag_out = fifo_empty ? '0 : rd_data[TAG_W-1:0];

`ifdef ALMOST_FULL_EN
    assign almost_full = (count_q >= (ADDR_W + 1)'(AF_LEVEL));
`endif

endmodule
